// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide control path.
// Holds the sequencer state encoding and the default iteration counts
// for a 32-bit radix-4 Booth multiply and a 32-bit non-restoring divide.
package multdiv_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StRun  = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } state_e;

    localparam int unsigned DefMultIters = 16;
    localparam int unsigned DefDivIters  = 32;
    localparam int unsigned DefCntW      = 6;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiply/divide sequencer.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset, count returns to 0
//   clear  - synchronous clear, wins over en
//   en     - count enable, increments by one per cycle
//   count  - current count value
module iter_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide unit. Sequences operand load,
// N iteration steps and, for divide, a final fix-up cycle, then pulses
// result_rdy. Holds no operand data.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset; aborts any operation
//   ctrl_MULT    - start multiply (one-cycle pulse); wins over ctrl_DIV
//   ctrl_DIV     - start divide (one-cycle pulse)
//   div_by_zero  - datapath divisor==0 flag, sampled during LOAD
//   op_load      - datapath latches operands, clears accumulators
//   op_step      - datapath performs one iteration
//   op_fix       - datapath performs divide remainder/sign correction
//   op_is_div    - current op is a divide (LOAD through DONE)
//   iter         - index of the step being performed
//   busy         - pipeline stall request
//   result_rdy   - result valid, one-cycle pulse
//   exception    - divide-by-zero, only together with result_rdy
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned MULT_ITERS = DefMultIters,
    parameter int unsigned DIV_ITERS  = DefDivIters,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             div_by_zero,
    output logic             op_load,
    output logic             op_step,
    output logic             op_fix,
    output logic             op_is_div,
    output logic [CNT_W-1:0] iter,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    state_e state_q, state_d;
    logic   div_q, div_d;
    logic   exc_q, exc_d;
    logic   iter_last;
    logic   cnt_clear;
    logic   cnt_en;

    // State register plus the per-operation flags captured on LOAD entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        iter_last = div_q ? (iter == CNT_W'(DIV_ITERS - 1))
                          : (iter == CNT_W'(MULT_ITERS - 1));
    end

    // Next-state logic. A start pulse in any state restarts into LOAD.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        exc_d   = exc_q;
        if (ctrl_MULT || ctrl_DIV) begin
            state_d = StLoad;
            div_d   = !ctrl_MULT;
            exc_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StLoad: begin
                    if (div_q && div_by_zero) begin
                        exc_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (iter_last) begin
                        state_d = div_q ? StFix : StDone;
                    end
                end
                StFix:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Clear on LOAD entry so iter already reads 0 during the LOAD cycle.
    // Enable stops at N-1 so iter holds its last value through FIX/DONE.
    always_comb begin
        cnt_clear = (state_d == StLoad);
        cnt_en    = op_step && !iter_last;
    end

    iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (iter)
    );

    // Moore output decode.
    always_comb begin
        op_load    = 1'b0;
        op_step    = 1'b0;
        op_fix     = 1'b0;
        busy       = 1'b0;
        result_rdy = 1'b0;
        exception  = 1'b0;
        op_is_div  = div_q && (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                op_load = 1'b1;
                busy    = 1'b1;
            end
            StRun: begin
                op_step = 1'b1;
                busy    = 1'b1;
            end
            StFix: begin
                op_fix = 1'b1;
                busy   = 1'b1;
            end
            StDone: begin
                result_rdy = 1'b1;
                exception  = exc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: per-cycle output checks against
// expected timing, plus a result scoreboard filled when operations start.
module tb_multdiv_sequencer;

    logic       clk;
    logic       reset;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       div_by_zero;
    logic       op_load;
    logic       op_step;
    logic       op_fix;
    logic       op_is_div;
    logic [5:0] iter;
    logic       busy;
    logic       result_rdy;
    logic       exception;

    typedef struct {
        int unsigned rdy_cyc;
        bit          exc;
        bit          is_div;
    } result_t;

    result_t     sb[$];
    int unsigned cyc;
    int          total;
    int          bad;

    localparam logic [31:0] CtrlMask = 32'h0000_1FC0;

    multdiv_sequencer u_dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_MULT   (ctrl_MULT),
        .ctrl_DIV    (ctrl_DIV),
        .div_by_zero (div_by_zero),
        .op_load     (op_load),
        .op_step     (op_step),
        .op_fix      (op_fix),
        .op_is_div   (op_is_div),
        .iter        (iter),
        .busy        (busy),
        .result_rdy  (result_rdy),
        .exception   (exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {19'b0, op_load, op_step, op_fix, busy, op_is_div, result_rdy, exception, iter};
    endfunction

    function automatic int lat_of(input bit is_div, input bit dbz);
        if (!is_div) return 18;
        return dbz ? 2 : 35;
    endfunction

    // Expected outputs in cycle k after the start pulse (k=1 is LOAD).
    function automatic logic [31:0] exp_vec(input bit is_div, input bit dbz, input int k);
        bit ld = 0, st = 0, fx = 0, bz = 0, rd = 0, ex = 0;
        int it = 0;
        int n  = is_div ? 32 : 16;
        if (k == 1) begin
            ld = 1; bz = 1;
        end else if (is_div && dbz) begin
            rd = 1; ex = 1;
        end else if (k <= n + 1) begin
            st = 1; bz = 1; it = k - 2;
        end else if (is_div && k == n + 2) begin
            fx = 1; bz = 1; it = n - 1;
        end else begin
            rd = 1; it = n - 1;
        end
        return {19'b0, ld, st, fx, bz, is_div, rd, ex, 6'(it)};
    endfunction

    // Result monitor: every result_rdy must match the oldest pending entry.
    always @(negedge clk) begin
        if (reset && result_rdy) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_rdy", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                result_t r;
                r = sb.pop_front();
                check_eq("sb_rdy_cycle", 32'(cyc), 32'(r.rdy_cyc));
                check_eq("sb_exception", 32'(exception), 32'(r.exc));
                check_eq("sb_is_div", 32'(op_is_div), 32'(r.is_div));
            end
        end
    end

    // Called at a negedge. Pulses the start inputs, then checks cycles 1..k_last.
    task automatic run_op(input bit m, input bit d, input bit dbz, input int k_last,
                          input string name, input bit abort);
        bit      is_div;
        int      lat;
        result_t r;
        is_div = !m && d;
        lat    = lat_of(is_div, dbz);
        if (abort && sb.size() > 0) void'(sb.pop_back());
        r.rdy_cyc = cyc + lat;
        r.exc     = is_div && dbz;
        r.is_div  = is_div;
        sb.push_back(r);
        div_by_zero = dbz;
        ctrl_MULT   = m;
        ctrl_DIV    = d;
        @(posedge clk);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        for (int k = 1; k <= k_last; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s k=%0d", name, k), obs(), exp_vec(is_div, dbz, k));
        end
        if (k_last == lat) begin
            @(negedge clk);
            check_eq($sformatf("%s idle", name), obs() & CtrlMask, 32'h0);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        reset       = 1'b0;
        ctrl_MULT   = 1'b0;
        ctrl_DIV    = 1'b0;
        div_by_zero = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", obs(), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("after_reset", obs(), 32'h0);

        run_op(1'b1, 1'b0, 1'b0, 18, "mul", 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 35, "div", 1'b0);
        run_op(1'b0, 1'b1, 1'b1, 2, "dbz", 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 35, "div_after_dbz", 1'b0);

        // Divide restart while the multiply sits at iter==7.
        run_op(1'b1, 1'b0, 1'b0, 9, "mul_abort", 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 35, "div_restart", 1'b1);

        // Async reset at divide iter==20, applied and released between edges.
        run_op(1'b0, 1'b1, 1'b0, 22, "div_rst", 1'b0);
        #1 reset = 1'b0;
        #1 check_eq("async_rst_outputs", obs(), 32'h0);
        sb.delete();
        #1 reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst idle %0d", i), obs() & CtrlMask, 32'h0);
        end

        run_op(1'b1, 1'b1, 1'b0, 18, "both", 1'b0);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
